// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the operand loader, the control FSM and the ALU.
//   FCT_W          width of a function code
//   ADD..CMP       function-code values
//   loader_state_e operand-loader frame state
package calc_pkg;

    localparam int unsigned FCT_W = 3;

    localparam logic [FCT_W-1:0] ADD = 3'd0;
    localparam logic [FCT_W-1:0] SUB = 3'd1;
    localparam logic [FCT_W-1:0] AND = 3'd2;
    localparam logic [FCT_W-1:0] OR  = 3'd3;
    localparam logic [FCT_W-1:0] XOR = 3'd4;
    localparam logic [FCT_W-1:0] CMP = 3'd5;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StLoadFct,
        StIssue,
        StWaitDone
    } loader_state_e;

endpackage

// File: rtl/calc_timeout.sv
// calc_timeout: wait-cycle counter for the operand loader.
//   clock_i    clock, rising edge
//   reset_i    asynchronous active-high reset
//   clear_i    force the count back to zero (has priority over enable_i)
//   enable_i   advance the count by one this cycle
//   expired_o  count has reached TIMEOUT-1
module calc_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    // Saturate at Last so the count never wraps if the caller lingers.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != Last)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == Last);

endmodule

// File: rtl/calc_loader.sv
// calc_loader: collects a three-word frame (operand A, operand B, function code)
// and hands it to the downstream control FSM.
//   clock_i    clock, rising edge
//   reset_i    asynchronous active-high reset
//   data_i     inbound word (A, B or function code by frame position)
//   valid_i    data_i valid this cycle
//   ready_o    loader accepts data_i this cycle
//   done_i     downstream has finished the current operation
//   a_o, b_o   registered operands
//   fct_o      registered function code
//   start_o    one-cycle operation request
//   error_o    one-cycle pulse, illegal function code (frame dropped)
//   timeout_o  one-cycle pulse, done_i not seen in time
module calc_loader
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_FCT = 6,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             done_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [FCT_W-1:0] fct_o,
    output logic             start_o,
    output logic             error_o,
    output logic             timeout_o
);

    // Compare the function code at no less than 32 bits so no upper bit of
    // data_i is lost against NUM_FCT.
    localparam int unsigned CmpW = (WIDTH > 32) ? WIDTH : 32;

    loader_state_e    state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [FCT_W-1:0] fct_q;
    logic             ready_q, start_q, error_q, timeout_q;

    logic [CmpW-1:0]  data_ext;
    logic             fct_legal;
    logic             transfer;
    logic             expired;
    logic             wait_active;

    assign data_ext    = CmpW'(data_i);
    assign fct_legal   = (data_ext < CmpW'(NUM_FCT));
    assign transfer    = valid_i & ready_q;
    assign wait_active = (state_q == StWaitDone);

    calc_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (~wait_active),
        .enable_i  (wait_active),
        .expired_o (expired)
    );

    // ready_q is registered from the next state, so it stays low during reset
    // and rises on the first edge after reset is released.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StLoadA;
            a_q       <= '0;
            b_q       <= '0;
            fct_q     <= '0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            start_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StLoadA: begin
                    if (transfer) begin
                        a_q     <= data_i;
                        state_q <= StLoadB;
                    end
                end
                StLoadB: begin
                    if (transfer) begin
                        b_q     <= data_i;
                        state_q <= StLoadFct;
                    end
                end
                StLoadFct: begin
                    if (transfer) begin
                        if (fct_legal) begin
                            fct_q   <= FCT_W'(data_i);
                            state_q <= StIssue;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= StLoadA;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWaitDone;
                    ready_q <= 1'b0;
                end
                StWaitDone: begin
                    // done_i has priority over an expiry in the same cycle.
                    if (done_i) begin
                        state_q <= StLoadA;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= StLoadA;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StLoadA;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign fct_o     = fct_q;
    assign start_o   = start_q;
    assign error_o   = error_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_calc_loader.sv
module tb_calc_loader;

    localparam int WIDTH   = 8;
    localparam int NUM_FCT = 6;
    localparam int TIMEOUT = 64;

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [WIDTH-1:0] data_i  = '0;
    logic             valid_i = 1'b0;
    logic             done_i  = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] a_o, b_o;
    logic [2:0]       fct_o;
    logic             start_o, error_o, timeout_o;

    calc_loader #(
        .WIDTH   (WIDTH),
        .NUM_FCT (NUM_FCT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .done_i    (done_i),
        .a_o       (a_o),
        .b_o       (b_o),
        .fct_o     (fct_o),
        .start_o   (start_o),
        .error_o   (error_o),
        .timeout_o (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame position plus the last accepted value of each field.
    int         pos = 0;
    logic [7:0] ma = '0, mb = '0;
    logic [2:0] mf = '0;
    logic       last_legal = 1'b0;
    int         start_cnt = 0;
    int         to_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Mid-cycle monitor: pulse counting and mutual exclusion of the pulses.
    always @(negedge clock_i) begin
        if (start_o === 1'b1) start_cnt++;
        if (timeout_o === 1'b1) to_cnt++;
        chk("pulses_exclusive", 32'(($countones({start_o, error_o, timeout_o}) <= 1)), 1);
    end

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_a"}, a_o, ma);
        chk({tag, "_b"}, b_o, mb);
        chk({tag, "_fct"}, fct_o, mf);
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        valid_i = 1'b0;
        done_i  = 1'b0;
        #1;
        ma = '0; mb = '0; mf = '0; pos = 0;
        chk_regs("reset");
        chk("reset_start", start_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_ready", ready_o, 0);
        tick;
        tick;
        reset_i = 1'b0;
        tick;
        chk("ready_after_reset", ready_o, 1);
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        valid_i = 1'b0;
        repeat (gap) tick;
        valid_i = 1'b1;
        data_i  = w;
        chk("ready_load", ready_o, 1);
        tick;
        valid_i = 1'b0;
        case (pos)
            0: ma = w;
            1: mb = w;
            default: begin
                last_legal = (int'(w) < NUM_FCT);
                if (last_legal) mf = w[2:0];
            end
        endcase
        chk_regs("xfer");
        if (pos == 2) begin
            chk("fct_start", start_o, 32'(last_legal));
            chk("fct_error", error_o, 32'(!last_legal));
        end
        pos = (pos + 1) % 3;
    endtask

    // Called in the ISSUE cycle; optionally drives done_i there (must be ignored).
    task automatic finish_op(input int delay, input logic done_in_issue);
        done_i = done_in_issue;
        tick;
        done_i = 1'b0;
        chk("ready_wait", ready_o, 0);
        chk("start_one_cycle", start_o, 0);
        repeat (delay) tick;
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        chk("ready_after_done", ready_o, 1);
        chk("no_timeout_on_done", timeout_o, 0);
        chk_regs("after_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int t;
        logic found;
        logic [7:0] ra, rb, rf;

        do_reset();

        // Basic frame.
        s0 = start_cnt;
        send_word(8'h12, 0);
        send_word(8'h34, 0);
        send_word(8'h02, 0);
        finish_op(0, 1'b0);
        chk("basic_start_count", start_cnt - s0, 1);

        // Backpressure: 0x55 held during WAIT_DONE.
        send_word(8'h21, 0);
        send_word(8'h43, 0);
        send_word(8'h01, 0);
        tick;
        valid_i = 1'b1;
        data_i  = 8'h55;
        repeat (3) begin
            tick;
            chk("bp_ready_low", ready_o, 0);
            chk_regs("bp_hold");
        end
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        chk("bp_ready_back", ready_o, 1);
        chk_regs("bp_no_early_load");
        tick;
        valid_i = 1'b0;
        ma = 8'h55;
        pos = 1;
        chk_regs("bp_loaded");
        send_word(8'h66, 0);
        send_word(8'h04, 0);
        finish_op(2, 1'b1);

        // Illegal function codes, including ones whose low bits look legal.
        s0 = start_cnt;
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        send_word(8'h06, 0);
        tick;
        chk("error_one_pulse", error_o, 0);
        send_word(8'h09, 0);
        send_word(8'h0A, 1);
        send_word(8'h0A, 0);
        send_word(8'h07, 0);
        send_word(8'h08, 0);
        send_word(8'h82, 2);
        chk("illegal_no_start", start_cnt - s0, 0);
        send_word(8'h03, 0);
        send_word(8'h04, 0);
        send_word(8'h05, 0);
        finish_op(1, 1'b0);

        // Timeout latency.
        send_word(8'h01, 0);
        send_word(8'h01, 0);
        send_word(8'h00, 0);
        tick;
        t = 0;
        found = 1'b0;
        while (!found && t < TIMEOUT + 8) begin
            tick;
            t++;
            if (timeout_o === 1'b1) found = 1'b1;
        end
        chk("timeout_latency", t, TIMEOUT);
        chk("ready_after_timeout", ready_o, 1);
        tick;
        chk("timeout_one_pulse", timeout_o, 0);
        chk_regs("after_timeout");

        // done_i in the expiry cycle wins.
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        send_word(8'h01, 0);
        tick;
        repeat (TIMEOUT - 1) tick;
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        chk("done_wins_timeout", timeout_o, 0);
        chk("done_wins_ready", ready_o, 1);
        tick;
        chk("done_wins_no_late_timeout", timeout_o, 0);

        // Mid-frame reset.
        send_word(8'hAA, 0);
        send_word(8'hBB, 0);
        do_reset();
        s0 = start_cnt;
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        send_word(8'h03, 0);
        finish_op(0, 1'b0);
        chk("midreset_start_count", start_cnt - s0, 1);

        // Reset during ISSUE, then during WAIT_DONE: no timeout afterwards.
        s0 = to_cnt;
        send_word(8'h05, 0);
        send_word(8'h06, 0);
        send_word(8'h01, 0);
        do_reset();
        repeat (TIMEOUT + 4) tick;
        send_word(8'h07, 0);
        send_word(8'h08, 0);
        send_word(8'h02, 0);
        tick;
        repeat (10) tick;
        do_reset();
        repeat (TIMEOUT + 4) tick;
        chk("reset_kills_timeout", to_cnt - s0, 0);

        // Randomized frames with idle gaps.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rf = 8'($urandom_range(NUM_FCT, 255));
            else rf = 8'($urandom_range(0, NUM_FCT - 1));
            s0 = start_cnt;
            send_word(ra, int'($urandom_range(0, 3)));
            send_word(rb, int'($urandom_range(0, 3)));
            send_word(rf, int'($urandom_range(0, 3)));
            if (last_legal) finish_op(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
            chk("rand_start_count", start_cnt - s0, 32'(last_legal));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
